// File: rtl/icmp_rx_buf_ctrl_if.sv
// Signal bundle for icmp_rx_buf_ctrl: receive stream, transmit stream, RAM ports and status.
// The slave modport is the controller's view; the master modport is the environment's view.
interface icmp_rx_buf_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_last;
  logic              rx_err;
  logic              rx_drop;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              pkt_avail;
  logic [ADDR_W:0]   pkt_len;
  logic              tx_start;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              tx_ready;

  modport slave (
    input  rx_valid, rx_data, rx_last, rx_err, ram_rd_data, tx_start, tx_ready,
    output rx_drop, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr,
           pkt_avail, pkt_len, tx_valid, tx_data, tx_last
  );

  modport master (
    output rx_valid, rx_data, rx_last, rx_err, ram_rd_data, tx_start, tx_ready,
    input  rx_drop, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr,
           pkt_avail, pkt_len, tx_valid, tx_data, tx_last
  );
endinterface

// File: rtl/icmp_rx_buf_ctrl.sv
// Single-packet receive buffer: writes one good packet into RAM from address 0, holds it,
// then streams it out through a 4-entry read-ahead FIFO that hides the RAM read latency.
module icmp_rx_buf_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  icmp_rx_buf_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | buffer empty, waiting for the first beat of a packet
  // RECV  | writing packet beats to RAM
  // DROP  | packet overflowed the buffer, discarding beats until rx_last
  // HOLD  | good packet held, waiting for tx_start
  // READ  | streaming the held packet out
  typedef enum logic [2:0] {IDLE, RECV, DROP, HOLD, READ} state_t;

  localparam logic [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]      FIFO_D = 4'd4;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wcnt_q, pkt_len_q, rd_cnt_q, tx_cnt_q;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [2:0]        inflight_q, fifo_cnt_q;
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_mem [4];
  logic              rx_drop_q;

  logic wr_en, wcnt_inc, wcnt_clr, len_load, drop_d, issue, read_done;
  logic ret, tx_valid, tx_last, tx_fire, rx_end, room;

  assign ret      = rd_pipe_q[RD_LAT-1];
  assign tx_valid = (fifo_cnt_q != 3'd0);
  assign tx_last  = tx_valid && (tx_cnt_q == pkt_len_q - ONE);
  assign tx_fire  = tx_valid && bus.tx_ready;
  assign rx_end   = bus.rx_valid && bus.rx_last;
  // Reads in flight already own a FIFO slot, so they count against the depth.
  assign room     = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < FIFO_D;

  assign bus.ram_wr_en   = wr_en;
  assign bus.ram_wr_addr = wcnt_q[ADDR_W-1:0];
  assign bus.ram_wr_data = bus.rx_data;
  assign bus.ram_rd_addr = rd_cnt_q[ADDR_W-1:0];
  assign bus.pkt_avail   = (state_q == HOLD) || (state_q == READ);
  assign bus.pkt_len     = pkt_len_q;
  assign bus.tx_valid    = tx_valid;
  assign bus.tx_data     = fifo_mem[rd_ptr_q];
  assign bus.tx_last     = tx_last;
  assign bus.rx_drop     = rx_drop_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    wcnt_inc  = 1'b0;
    wcnt_clr  = 1'b0;
    len_load  = 1'b0;
    drop_d    = 1'b0;
    issue     = 1'b0;
    read_done = 1'b0;
    case (state_q)
      IDLE, RECV: begin
        if (bus.rx_valid) begin
          if (wcnt_q[ADDR_W]) begin
            // Buffer already full: this beat has no RAM slot.
            if (bus.rx_last) begin
              drop_d   = 1'b1;
              wcnt_clr = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = DROP;
            end
          end else begin
            wr_en    = 1'b1;
            wcnt_inc = 1'b1;
            if (!bus.rx_last) begin
              state_d = RECV;
            end else if (bus.rx_err) begin
              drop_d   = 1'b1;
              wcnt_clr = 1'b1;
              state_d  = IDLE;
            end else begin
              len_load = 1'b1;
              state_d  = HOLD;
            end
          end
        end
      end
      DROP: begin
        if (rx_end) begin
          drop_d   = 1'b1;
          wcnt_clr = 1'b1;
          state_d  = IDLE;
        end
      end
      HOLD: begin
        drop_d = rx_end;
        if (bus.tx_start) begin
          issue   = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        drop_d = rx_end;
        issue  = (rd_cnt_q < pkt_len_q) && room;
        if (tx_fire && tx_last) begin
          read_done = 1'b1;
          wcnt_clr  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q     <= '0;
      pkt_len_q  <= '0;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      rd_pipe_q  <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_drop_q  <= 1'b0;
    end else begin
      rx_drop_q <= drop_d;
      if (wcnt_clr)      wcnt_q <= '0;
      else if (wcnt_inc) wcnt_q <= wcnt_q + ONE;
      if (len_load) pkt_len_q <= wcnt_q + ONE;
      if (read_done) begin
        rd_cnt_q   <= '0;
        tx_cnt_q   <= '0;
        rd_pipe_q  <= '0;
        inflight_q <= '0;
        fifo_cnt_q <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        rd_pipe_q  <= rd_pipe_d;
        inflight_q <= inflight_q + {2'b00, issue} - {2'b00, ret};
        fifo_cnt_q <= fifo_cnt_q + {2'b00, ret} - {2'b00, tx_fire};
        if (issue) rd_cnt_q <= rd_cnt_q + ONE;
        if (ret)   wr_ptr_q <= wr_ptr_q + 2'd1;
        if (tx_fire) begin
          tx_cnt_q <= tx_cnt_q + ONE;
          rd_ptr_q <= rd_ptr_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ret) fifo_mem[wr_ptr_q] <= bus.ram_rd_data;
  end
endmodule

// File: tb/tb_icmp_rx_buf_ctrl.sv
// Bench for icmp_rx_buf_ctrl: a packet-level model (queues of received bytes) checks the
// outputs every cycle, and directed plus randomized packets exercise the buffer.
module tb_icmp_rx_buf_ctrl;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int MAXP   = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   drop_cnt = 0;

  icmp_rx_buf_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  icmp_rx_buf_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM with registered address and registered output: two cycles of read latency.
  logic [7:0]        mem [MAXP];
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_d_q;
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    ram_a_q <= bus.ram_rd_addr;
    ram_d_q <= mem[ram_a_q];
  end
  assign bus.ram_rd_data = ram_d_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Packet-level model: current packet bytes, held packet bytes and read position.
  logic [7:0] m_cur[$];
  logic [7:0] m_held[$];
  logic [7:0] m_prev_data;
  bit m_hold, m_read, m_ovf, m_drop, m_prev_stall, was_hold, was_read, exp_wr;
  int m_idx;

  always @(negedge clk) begin
    if (rst) begin
      m_cur.delete();
      m_hold = 0; m_read = 0; m_ovf = 0; m_drop = 0; m_prev_stall = 0; m_idx = 0;
    end else begin
      was_hold = m_hold;
      was_read = m_read;
      if (bus.rx_drop) drop_cnt++;
      chk("pkt_avail", int'(bus.pkt_avail), int'(m_hold));
      chk("rx_drop", int'(bus.rx_drop), int'(m_drop));
      if (m_hold) chk("pkt_len", int'(bus.pkt_len), m_held.size());
      if (!m_read) chk("tx_valid_idle", int'(bus.tx_valid), 0);
      else if (bus.tx_valid) begin
        chk("tx_data", int'(bus.tx_data), int'(m_held[m_idx]));
        chk("tx_last", int'(bus.tx_last), int'(m_idx == m_held.size() - 1));
      end
      if (m_prev_stall) begin
        chk("stall_valid", int'(bus.tx_valid), 1);
        chk("stall_data", int'(bus.tx_data), int'(m_prev_data));
      end
      exp_wr = bus.rx_valid && !m_hold && !m_ovf && (m_cur.size() < MAXP);
      // A discarded packet's final byte may or may not be written.
      if (!(exp_wr && bus.rx_last && bus.rx_err)) begin
        chk("ram_wr_en", int'(bus.ram_wr_en), int'(exp_wr));
        if (exp_wr) begin
          chk("ram_wr_addr", int'(bus.ram_wr_addr), m_cur.size());
          chk("ram_wr_data", int'(bus.ram_wr_data), int'(bus.rx_data));
        end
      end

      m_drop = 0;
      if (bus.rx_valid) begin
        if (was_hold) begin
          if (bus.rx_last) m_drop = 1;
        end else if (m_ovf || m_cur.size() == MAXP) begin
          if (bus.rx_last) begin
            m_drop = 1; m_ovf = 0; m_cur.delete();
          end else m_ovf = 1;
        end else begin
          m_cur.push_back(bus.rx_data);
          if (bus.rx_last) begin
            if (bus.rx_err) m_drop = 1;
            else begin m_held = m_cur; m_hold = 1; end
            m_cur.delete();
          end
        end
      end
      m_prev_stall = bus.tx_valid && !bus.tx_ready;
      m_prev_data  = bus.tx_data;
      if (was_read && bus.tx_valid && bus.tx_ready) begin
        m_idx++;
        if (m_idx == m_held.size()) begin m_read = 0; m_hold = 0; end
      end
      if (was_hold && !was_read && bus.tx_start) begin m_read = 1; m_idx = 0; end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pattern mode: (start+i) ^ (i>>8), so byte 2048 differs from byte 0.
  task automatic send_pkt(input int len, input int start, input bit rnd_data, input bit err,
                          input bit gaps, output logic [7:0] first);
    first = 8'h00;
    for (int i = 0; i < len; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        bus.rx_valid = 1'b0; bus.rx_last = 1'b0; bus.rx_err = 1'b0;
      end
      @(posedge clk); #1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = rnd_data ? 8'($urandom) : (8'(start + i) ^ 8'(i >> 8));
      bus.rx_last  = (i == len - 1);
      bus.rx_err   = err && (i == len - 1);
      if (i == 0) first = bus.rx_data;
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.rx_last = 1'b0; bus.rx_err = 1'b0;
  endtask

  task automatic read_pkt(input bit rnd, input int len, output int first_data, output int last_data);
    int beats, first, bubbles, t;
    bit done;
    beats = 0; first = -1; bubbles = 0; t = 0; done = 0;
    first_data = -1; last_data = -1;
    @(posedge clk); #1;
    bus.tx_start = 1'b1;
    bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    while (!done && t < 8 * len + 50) begin
      if (bus.tx_valid) begin
        if (first < 0) first = t;
        if (bus.tx_ready) begin
          beats++;
          if (beats == 1) first_data = int'(bus.tx_data);
          if (bus.tx_last) begin last_data = int'(bus.tx_data); done = 1; end
        end
      end else if (first >= 0) bubbles++;
      if (!done) begin
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        t++;
        @(negedge clk);
      end
    end
    chk("read_done", int'(done), 1);
    chk("beat_count", beats, len);
    if (!rnd) begin
      chk("first_latency", int'(first >= 0 && first <= RD_LAT + 2), 1);
      chk("bubbles", bubbles, 0);
    end
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    bus.tx_ready = 1'b0;
    chk("avail_after_read", int'(bus.pkt_avail), 0);
  endtask

  initial begin
    logic [7:0] f0;
    int fd, ld, d0, beats, t, len;
    bit err;
    for (int i = 0; i < MAXP; i++) mem[i] = 8'h00;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_last = 1'b0; bus.rx_err = 1'b0;
    bus.tx_start = 1'b0; bus.tx_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pkt_avail", int'(bus.pkt_avail), 0);
    chk("rst_pkt_len", int'(bus.pkt_len), 0);
    chk("rst_tx_valid", int'(bus.tx_valid), 0);
    chk("rst_tx_last", int'(bus.tx_last), 0);
    chk("rst_ram_wr_en", int'(bus.ram_wr_en), 0);
    chk("rst_rx_drop", int'(bus.rx_drop), 0);
    chk("rst_ram_rd_addr", int'(bus.ram_rd_addr), 0);

    // tx_start with nothing held must be ignored
    bus.tx_start = 1'b1; bus.tx_ready = 1'b1;
    idle(1);
    bus.tx_start = 1'b0;
    idle(4);
    chk("start_in_idle", int'(bus.tx_valid), 0);
    bus.tx_ready = 1'b0;

    // 64-byte incrementing packet, full-rate read
    send_pkt(64, 0, 0, 0, 0, f0);
    chk("len64", int'(bus.pkt_len), 64);
    read_pkt(0, 64, fd, ld);
    chk("len64_first", fd, 8'h00);
    chk("len64_last", ld, 8'h3F);

    // same packet, random backpressure
    send_pkt(64, 0, 0, 0, 1, f0);
    read_pkt(1, 64, fd, ld);
    chk("len64_rnd_last", ld, 8'h3F);

    // errored packet then single-byte packet
    d0 = drop_cnt;
    send_pkt(10, 8'h20, 0, 1, 0, f0);
    idle(3);
    chk("err_drop_count", drop_cnt - d0, 1);
    chk("err_no_avail", int'(bus.pkt_avail), 0);
    send_pkt(1, 8'hA5, 0, 0, 0, f0);
    chk("len1", int'(bus.pkt_len), 1);
    read_pkt(0, 1, fd, ld);
    chk("len1_data", fd, 8'hA5);
    chk("len1_last", ld, 8'hA5);

    // largest packet accepted, one byte more is dropped
    send_pkt(MAXP, 0, 1, 0, 0, f0);
    chk("len_max", int'(bus.pkt_len), 2048);
    read_pkt(1, MAXP, fd, ld);
    d0 = drop_cnt;
    send_pkt(MAXP + 1, 8'h11, 0, 0, 0, f0);
    idle(3);
    chk("ovf1_drop_count", drop_cnt - d0, 1);
    chk("ovf1_no_avail", int'(bus.pkt_avail), 0);
    chk("ovf1_mem0", int'(mem[0]), int'(f0));
    d0 = drop_cnt;
    send_pkt(MAXP + 2, 8'h37, 0, 0, 0, f0);
    idle(3);
    chk("ovf2_drop_count", drop_cnt - d0, 1);
    chk("ovf2_mem0", int'(mem[0]), int'(f0));

    // second packet while the first is held
    send_pkt(16, 8'h80, 0, 0, 0, f0);
    d0 = drop_cnt;
    send_pkt(5, 8'hC0, 0, 0, 0, f0);
    idle(2);
    chk("busy_drop_count", drop_cnt - d0, 1);
    chk("busy_len", int'(bus.pkt_len), 16);
    read_pkt(0, 16, fd, ld);
    chk("busy_first", fd, 8'h80);
    chk("busy_last", ld, 8'h8F);

    // randomized packets
    for (int k = 0; k < 12; k++) begin
      len = $urandom_range(1, 80);
      err = ($urandom_range(0, 4) == 0);
      send_pkt(len, 0, 1, err, 1, f0);
      if (!err) begin
        if ($urandom_range(0, 1) == 1) send_pkt($urandom_range(1, 6), 0, 1, 0, 1, f0);
        read_pkt(1'($urandom_range(0, 1)), len, fd, ld);
      end else idle(2);
    end

    // reset in the middle of a read
    send_pkt(40, 8'h40, 0, 0, 0, f0);
    @(posedge clk); #1;
    bus.tx_start = 1'b1; bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    beats = 0; t = 0;
    while (beats < 20 && t < 200) begin
      @(negedge clk);
      if (bus.tx_valid && bus.tx_ready) beats++;
      t++;
    end
    chk("beats_before_rst", beats, 20);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.tx_ready = 1'b0;
    chk("midrst_tx_valid", int'(bus.tx_valid), 0);
    chk("midrst_pkt_avail", int'(bus.pkt_avail), 0);
    chk("midrst_pkt_len", int'(bus.pkt_len), 0);
    idle(4);
    chk("midrst_stale_data", int'(bus.tx_valid), 0);
    send_pkt(8, 0, 1, 0, 0, f0);
    chk("len8", int'(bus.pkt_len), 8);
    read_pkt(0, 8, fd, ld);
    chk("len8_first", fd, int'(f0));

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
